// File: rtl/tea_pkg.sv
// Shared TEA constants and types, used by both the encryptor and the decryptor.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
  localparam logic [31:0] TEA_SUM32 = 32'hC6EF3720;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_t;

  // k[0] is the most significant word of the 128-bit key.
  typedef logic [0:3][31:0] tea_key_t;

endpackage

// File: rtl/tea_enc_round.sv
// One full TEA encryption cycle (both half-rounds), purely combinational.
module tea_enc_round
  import tea_pkg::*;
(
  input  logic [31:0] i_v0,
  input  logic [31:0] i_v1,
  input  logic [31:0] i_sum,
  input  tea_key_t    i_key,
  output logic [31:0] o_v0,
  output logic [31:0] o_v1,
  output logic [31:0] o_sum
);

  logic [31:0] w_sum;
  logic [31:0] w_v0;

  assign w_sum = i_sum + TEA_DELTA;

  // The freshly updated v0 feeds the v1 half-round in the same cycle.
  assign w_v0 = i_v0 + (((i_v1 << 4) + i_key[0]) ^ (i_v1 + w_sum) ^ ((i_v1 >> 5) + i_key[1]));

  assign o_v0  = w_v0;
  assign o_v1  = i_v1 + (((w_v0 << 4) + i_key[2]) ^ (w_v0 + w_sum) ^ ((w_v0 >> 5) + i_key[3]));
  assign o_sum = w_sum;

endmodule

// File: rtl/tea_enc_asmd.sv
// Iterative TEA encryptor: one TEA cycle per enabled clock, valid/ready on both sides.
module tea_enc_asmd
  import tea_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  localparam int CW = $clog2(ROUNDS + 1);

  tea_state_t  r_state;
  logic [31:0] r_v0;
  logic [31:0] r_v1;
  logic [31:0] r_sum;
  tea_key_t    r_key;
  logic [CW-1:0] r_cnt;
  logic        r_outValid;
  logic        r_busy;

  logic [31:0] w_v0Next;
  logic [31:0] w_v1Next;
  logic [31:0] w_sumNext;

  tea_enc_round u_round (
    .i_v0  (r_v0),
    .i_v1  (r_v1),
    .i_sum (r_sum),
    .i_key (r_key),
    .o_v0  (w_v0Next),
    .o_v1  (w_v1Next),
    .o_sum (w_sumNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_v0       <= '0;
      r_v1       <= '0;
      r_sum      <= '0;
      r_key      <= '0;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_v0    <= in_data[63:32];
            r_v1    <= in_data[31:0];
            r_key   <= in_key;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_v0  <= w_v0Next;
          r_v1  <= w_v1Next;
          r_sum <= w_sumNext;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ROUNDS - 1)) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && ena;
  assign out_valid = r_outValid;
  assign out_data  = {r_v0, r_v1};
  assign busy      = r_busy;

endmodule

// File: tb/tb_tea_enc_asmd.sv
// Randomized and directed checks of tea_enc_asmd against a plain-arithmetic TEA model.
module tb_tea_enc_asmd;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  tea_enc_asmd #(.ROUNDS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference TEA, written like the textbook C routines.
  function automatic logic [63:0] teaEnc(input logic [63:0] d, input logic [127:0] k, input int rounds);
    logic [31:0] v0, v1, s;
    v0 = d[63:32]; v1 = d[31:0]; s = 32'h0;
    for (int i = 0; i < rounds; i++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] teaDec(input logic [63:0] d, input logic [127:0] k, input int rounds);
    logic [31:0] v0, v1, s;
    v0 = d[63:32]; v1 = d[31:0]; s = 32'h9E3779B9 * rounds;
    for (int i = 0; i < rounds; i++) begin
      v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
      v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      s  = s - 32'h9E3779B9;
    end
    return {v0, v1};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid, counting edges; optionally freeze ena for freezeLen edges at edge freezeAt.
  task automatic waitValid(input int freezeAt, input int freezeLen, output int lat);
    logic [63:0] held;
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (lat == freezeAt) begin
        ena = 1'b0;
        held = out_data;
        repeat (freezeLen) begin
          @(posedge clk); #1;
          lat++;
          checkOutput("freeze_data", out_data, held);
          checkOutput("freeze_valid", {63'b0, out_valid}, 64'd0);
        end
        ena = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  // Offer a block, run it to completion and hand it off.
  task automatic applyStimulus(input string tag, input logic [63:0] d, input logic [127:0] k,
                               input int freezeAt, input int freezeLen, input int expLat);
    int lat;
    logic [63:0] res;
    in_valid = 1'b1; in_data = d; in_key = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    waitValid(freezeAt, freezeLen, lat);
    res = out_data;
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_cipher"}, res, teaEnc(d, k, 32));
    checkOutput({tag, "_roundtrip"}, teaDec(res, k, 32), d);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_valid"}, {63'b0, out_valid}, 64'd0);
    checkOutput({tag, "_idle_ready"}, {63'b0, in_ready}, 64'd1);
    checkOutput({tag, "_hold_data"}, out_data, res);
  endtask

  initial begin
    int lat;
    logic [63:0] held, dA, dB;
    logic [127:0] kA;

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0;
    #12;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd1);
    ena = 1'b0; #1;
    checkOutput("rst_in_ready_noena", {63'b0, in_ready}, 64'd0);
    ena = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero key / zero plaintext known answer, then the internal sum.
    applyStimulus("zero", 64'd0, 128'd0, -1, 0, 32);
    checkOutput("zero_known", out_data, 64'h41EA3A0A_94BAA940);
    checkOutput("zero_sum", {32'b0, dut.r_sum}, {32'b0, 32'hC6EF3720});

    applyStimulus("std", 64'h01234567_89ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, -1, 0, 32);

    // Backpressure with a competing in_valid.
    kA = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    dA = {$urandom, $urandom};
    in_valid = 1'b1; in_data = dA; in_key = kA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitValid(-1, 0, lat);
    checkOutput("bp_cipher", out_data, teaEnc(dA, kA, 32));
    held = out_data;
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", {63'b0, out_valid}, 64'd1);
      checkOutput("bp_data", out_data, held);
      checkOutput("bp_in_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("bp_release_busy", {63'b0, busy}, 64'd0);
    checkOutput("bp_release_data", out_data, held);

    // Freeze for 5 cycles after round 10.
    applyStimulus("freeze", 64'd0, 128'd0, 10, 5, 37);
    checkOutput("freeze_known", out_data, 64'h41EA3A0A_94BAA940);

    // Reset in the middle of a run.
    in_valid = 1'b1; in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (16) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0; #1;
    checkOutput("midrst_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("midrst_data", out_data, 64'd0);
    checkOutput("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("postrst", 64'd0, 128'd0, -1, 0, 32);
    checkOutput("postrst_known", out_data, 64'h41EA3A0A_94BAA940);

    // Back-to-back with in_valid held high.
    dA = {$urandom, $urandom};
    dB = {$urandom, $urandom};
    kA = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = dA; in_key = kA;
    @(posedge clk); #1;
    in_data = dB;
    waitValid(-1, 0, lat);
    checkOutput("b2b_latA", 64'(lat), 64'd32);
    checkOutput("b2b_cipherA", out_data, teaEnc(dA, kA, 32));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2b_ready_after_handoff", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("b2b_acceptB_busy", {63'b0, busy}, 64'd1);
    checkOutput("b2b_acceptB_ready", {63'b0, in_ready}, 64'd0);
    waitValid(-1, 0, lat);
    checkOutput("b2b_latB", 64'(lat), 64'd32);
    checkOutput("b2b_cipherB", out_data, teaEnc(dB, kA, 32));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random blocks.
    for (int i = 0; i < 6; i++) begin
      applyStimulus("rand", {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, -1, 0, 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tea_enc_asmd.md
# tea_enc_asmd

Iterative TEA (Tiny Encryption Algorithm) encryptor: accepts one 64-bit plaintext block and a 128-bit key over a valid/ready handshake. It runs one full TEA cycle (both half-rounds) per clock and returns the 64-bit ciphertext over a second valid/ready handshake. It is the encrypt-side counterpart of the team's TEA decryptor. It produces the ciphertext vectors that the decryptor and key-search path consume, using the same DELTA, round count and word ordering.

## Interface
- ROUNDS, 32: number of TEA cycles, legal range 1..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  clock enable. When low, all state is frozen and no handshake completes.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  block can accept. Equals (state==IDLE) && ena.
- in_data  in  64  plaintext. v0 = in_data[63:32], v1 = in_data[31:0].
- in_key  in  128  key. k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- out_data  out  64  ciphertext {v0, v1}.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - On in_valid && in_ready: latch v0, v1 and the key; sum <= 0; cnt <= 0; go to RUN.
  - Otherwise hold.
- **RUN**, on each enabled edge:
  - s' = sum + DELTA, where DELTA = 32'h9E3779B9.
  - v0' = v0 + (((v1<<4)+k0) ^ (v1+s') ^ ((v1>>5)+k1)).
  - v1' = v1 + (((v0'<<4)+k2) ^ (v0'+s') ^ ((v0'>>5)+k3)).
  - sum <= s'; cnt <= cnt+1.
  - When cnt == ROUNDS-1 this edge performs the last round and state goes to DONE.
- **DONE**
  - out_valid = 1.
  - On out_valid && out_ready && ena: go to IDLE.
  - out_valid deasserts from the next cycle.
- Arithmetic:
  - All arithmetic is 32-bit modulo 2^32.
  - Shifts are logical.
  - v0' (the updated value) feeds the v1 update within the same cycle.
- cnt width is $clog2(ROUNDS+1).
- After a full 32-round run, sum = 32'hC6EF3720. This is the decryptor's starting sum.
- in_data and in_key are sampled only at the accepting edge. Later changes are ignored.
- in_valid in RUN or DONE is ignored, since in_ready is low.
- out_data is driven directly from the v0/v1 registers.
  - It holds the ciphertext after handoff until the next acceptance.
  - It changes during RUN and is only meaningful while out_valid is high.

## Timing
- Reset values:
  - state IDLE, v0 = v1 = sum = cnt = 0, key = 0.
  - out_valid 0, out_data 0, busy 0.
  - in_ready equals ena.
- rst_n asserted at any time, including mid-RUN or in DONE with out_valid high:
  - Immediately returns to the reset values.
  - The pending result is discarded.
- Latency with ena held high: out_valid rises exactly ROUNDS edges after the accepting edge.
- Throughput: at most one block per ROUNDS+2 cycles, because in_ready is never asserted in DONE.
- ena low for N cycles anywhere in an operation:
  - Latency grows by exactly N.
  - Result is unchanged.
  - out_valid and out_data stay stable while frozen.
- Backpressure: in DONE with out_ready low, out_valid and out_data remain stable indefinitely.
- All outputs except in_ready are registered. in_ready is the only combinational output.

## Structure
- Package tea_pkg holds:
  - TEA_DELTA = 32'h9E3779B9 and TEA_SUM32 = 32'hC6EF3720.
  - The state enum typedef (IDLE/RUN/DONE).
  - A key-word typedef (k[0:3], 32 bits each).
- The decryptor uses the same package constants.
- Sub-module tea_enc_round is purely combinational:
  - Inputs: v0, v1, sum, k0..k3.
  - Outputs: v0', v1', s'.
- The FSM, counter and registers live in tea_enc_asmd.

## Test plan
- Key 0 with plaintext 0 -> out_data = 64'h41EA3A0A_94BAA940. out_valid rises exactly 32 edges after acceptance; the internal sum is 32'hC6EF3720.
- Key 128'h00112233_44556677_8899AABB_CCDDEEFF with plaintext 64'h01234567_89ABCDEF:
  - out_data matches the C reference model.
  - Feeding out_data and the key to the software TEA decrypt model returns 64'h01234567_89ABCDEF.
- Backpressure: hold out_ready low for 10 cycles after out_valid rises, and pulse in_valid with new data.
  - out_valid and out_data stay stable.
  - in_ready stays 0 and the new data is not accepted.
  - After out_ready is raised, return to IDLE on the next cycle.
- ena low for 5 cycles at round 10 -> the ciphertext is identical to the first scenario and latency is 37 edges.
- rst_n low at round 16, then released -> out_valid = 0, out_data = 0, in_ready = 1. A following zero-vector operation still yields 64'h41EA3A0A_94BAA940.
- Back-to-back: in_valid held high with two different blocks -> the second is accepted exactly one cycle after the first handoff. Both ciphertexts match the model.
